icache_axi_rd_arbiter: RTL and testbench

Round-robin arbiter that lets NUM_MASTERS per-core instruction cache controllers share one AXI4 read port to main memory. Each cache controller issues a single-burst line fill (AR handshake, then WORDS_PER_LINE beats on R). The arbiter grants one master at a time and holds the grant until the R beat carrying `last` completes, so bursts are never interleaved. It sits between the per-core cache controllers and the memory interconnect in the multicore top level.

---
 rtl/icache_axi_rd_arbiter.sv | 162 ++++++++++++++++
 tb/tb_icache_axi_rd_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : icache_axi_rd_arbiter
// Brief    : Round-robin arbiter sharing one AXI4 read port among per-core
//            instruction cache controllers; grant held for a whole burst.
// Revision : 1.0  initial release
// ============================================================================
module icache_axi_rd_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                                i_clk,
    input  logic                                i_areset_n,
    // upstream read ports, one per cache controller
    input  logic [NUM_MASTERS-1:0]              s_axi_arvalid_i,
    output logic [NUM_MASTERS-1:0]              s_axi_arready_o,
    input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]  s_axi_araddr_i,
    input  logic [NUM_MASTERS-1:0][7:0]         s_axi_arlen_i,
    input  logic [NUM_MASTERS-1:0][2:0]         s_axi_arsize_i,
    input  logic [NUM_MASTERS-1:0][1:0]         s_axi_arburst_i,
    output logic [NUM_MASTERS-1:0]              s_axi_rvalid_o,
    input  logic [NUM_MASTERS-1:0]              s_axi_rready_i,
    output logic [NUM_MASTERS-1:0][DATA_W-1:0]  s_axi_rdata_o,
    output logic [NUM_MASTERS-1:0][1:0]         s_axi_rresp_o,
    output logic [NUM_MASTERS-1:0]              s_axi_rlast_o,
    output logic [NUM_MASTERS-1:0]              s_axi_awready_o,
    output logic [NUM_MASTERS-1:0]              s_axi_wready_o,
    output logic [NUM_MASTERS-1:0]              s_axi_bvalid_o,
    // downstream read port to memory
    output logic                                m_axi_arvalid_o,
    input  logic                                m_axi_arready_i,
    output logic [ADDR_W-1:0]                   m_axi_araddr_o,
    output logic [7:0]                          m_axi_arlen_o,
    output logic [2:0]                          m_axi_arsize_o,
    output logic [1:0]                          m_axi_arburst_o,
    input  logic                                m_axi_rvalid_i,
    output logic                                m_axi_rready_o,
    input  logic [DATA_W-1:0]                   m_axi_rdata_i,
    input  logic [1:0]                          m_axi_rresp_i,
    input  logic                                m_axi_rlast_i,
    output logic                                m_axi_awvalid_o,
    output logic                                m_axi_wvalid_o,
    output logic                                m_axi_bready_o,
    // status
    output logic [NUM_MASTERS-1:0]              o_grant,
    output logic                                o_busy
);

    localparam int c_IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [c_IDX_W:0] c_NUM_EXT = (c_IDX_W+1)'(NUM_MASTERS);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ADDR = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [c_IDX_W-1:0] gnt_q, gnt_d;
    logic [c_IDX_W-1:0] last_q, last_d;

    logic               scan_found;
    logic [c_IDX_W:0]   scan_sum;
    logic [c_IDX_W-1:0] scan_idx;

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q <= c_ST_IDLE;
            gnt_q   <= '0;
            last_q  <= c_IDX_W'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // Scan order starts just after the previous owner, so it ends up lowest priority.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        scan_found = 1'b0;
        scan_sum   = '0;
        scan_idx   = '0;
        case (state_q)
            c_ST_IDLE: begin
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    scan_sum = {1'b0, last_q} + (c_IDX_W+1)'(i + 1);
                    if (scan_sum >= c_NUM_EXT) begin
                        scan_sum = scan_sum - c_NUM_EXT;
                    end
                    scan_idx = scan_sum[c_IDX_W-1:0];
                    if (!scan_found && s_axi_arvalid_i[scan_idx]) begin
                        scan_found = 1'b1;
                        gnt_d      = scan_idx;
                        state_d    = c_ST_ADDR;
                    end
                end
            end
            c_ST_ADDR: begin
                if (s_axi_arvalid_i[gnt_q] && m_axi_arready_i) begin
                    state_d = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (m_axi_rvalid_i && s_axi_rready_i[gnt_q] && m_axi_rlast_i) begin
                    state_d = c_ST_IDLE;
                    last_d  = gnt_q;
                end
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        s_axi_arready_o = '0;
        s_axi_rvalid_o  = '0;
        m_axi_arvalid_o = 1'b0;
        m_axi_rready_o  = 1'b0;
        o_grant         = '0;
        o_busy          = 1'b0;
        case (state_q)
            c_ST_ADDR: begin
                m_axi_arvalid_o        = s_axi_arvalid_i[gnt_q];
                s_axi_arready_o[gnt_q] = m_axi_arready_i;
                o_grant[gnt_q]         = 1'b1;
                o_busy                 = 1'b1;
            end
            c_ST_DATA: begin
                m_axi_rready_o         = s_axi_rready_i[gnt_q];
                s_axi_rvalid_o[gnt_q]  = m_axi_rvalid_i;
                o_grant[gnt_q]         = 1'b1;
                o_busy                 = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign m_axi_araddr_o  = s_axi_araddr_i[gnt_q];
    assign m_axi_arlen_o   = s_axi_arlen_i[gnt_q];
    assign m_axi_arsize_o  = s_axi_arsize_i[gnt_q];
    assign m_axi_arburst_o = s_axi_arburst_i[gnt_q];

    // Payload fans out to everyone; only the owner ever sees rvalid.
    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_rbcast
        assign s_axi_rdata_o[k] = m_axi_rdata_i;
        assign s_axi_rresp_o[k] = m_axi_rresp_i;
        assign s_axi_rlast_o[k] = m_axi_rlast_i;
    end

    assign s_axi_awready_o = '0;
    assign s_axi_wready_o  = '0;
    assign s_axi_bvalid_o  = '0;
    assign m_axi_awvalid_o = 1'b0;
    assign m_axi_wvalid_o  = 1'b0;
    assign m_axi_bready_o  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_icache_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_axi_rd_arbiter
// Brief    : Scoreboard bench for the instruction-cache AXI read arbiter.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_icache_axi_rd_arbiter;

    localparam int N = 4;

    typedef struct { int m; logic [31:0] a; logic [7:0] l; } arexp_t;
    typedef struct { int m; logic [31:0] d; logic l; } rexp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [N-1:0]         s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [N-1:0][31:0]   s_araddr, s_rdata;
    logic [N-1:0][7:0]    s_arlen;
    logic [N-1:0][2:0]    s_arsize;
    logic [N-1:0][1:0]    s_arburst, s_rresp;
    logic [N-1:0]         s_awready, s_wready, s_bvalid;
    logic                 m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [31:0]          m_araddr, m_rdata;
    logic [7:0]           m_arlen;
    logic [2:0]           m_arsize;
    logic [1:0]           m_arburst, m_rresp;
    logic                 m_awvalid, m_wvalid, m_bready;
    logic [N-1:0]         grant;
    logic                 busy;

    icache_axi_rd_arbiter #(.NUM_MASTERS(N), .ADDR_W(32), .DATA_W(32)) dut (
        .i_clk(clk), .i_areset_n(rst_n),
        .s_axi_arvalid_i(s_arvalid), .s_axi_arready_o(s_arready),
        .s_axi_araddr_i(s_araddr), .s_axi_arlen_i(s_arlen),
        .s_axi_arsize_i(s_arsize), .s_axi_arburst_i(s_arburst),
        .s_axi_rvalid_o(s_rvalid), .s_axi_rready_i(s_rready),
        .s_axi_rdata_o(s_rdata), .s_axi_rresp_o(s_rresp), .s_axi_rlast_o(s_rlast),
        .s_axi_awready_o(s_awready), .s_axi_wready_o(s_wready), .s_axi_bvalid_o(s_bvalid),
        .m_axi_arvalid_o(m_arvalid), .m_axi_arready_i(m_arready),
        .m_axi_araddr_o(m_araddr), .m_axi_arlen_o(m_arlen),
        .m_axi_arsize_o(m_arsize), .m_axi_arburst_o(m_arburst),
        .m_axi_rvalid_i(m_rvalid), .m_axi_rready_o(m_rready),
        .m_axi_rdata_i(m_rdata), .m_axi_rresp_i(m_rresp), .m_axi_rlast_i(m_rlast),
        .m_axi_awvalid_o(m_awvalid), .m_axi_wvalid_o(m_wvalid), .m_axi_bready_o(m_bready),
        .o_grant(grant), .o_busy(busy)
    );

    int checks = 0;
    int errors = 0;

    arexp_t exp_ar[$];
    rexp_t  exp_r[$];

    int          pend_cnt [N];
    logic [31:0] pend_addr[N];
    logic [7:0]  pend_len [N];
    int          ar_stall  = 0;
    bit          r_gaps    = 1'b0;
    bit          rr_toggle = 1'b0;
    int          r_hs_cnt  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_burst(input int m, input logic [31:0] a, input logic [7:0] l);
        arexp_t ea;
        rexp_t  er;
        ea.m = m; ea.a = a; ea.l = l;
        exp_ar.push_back(ea);
        for (int b = 0; b <= int'(l); b++) begin
            er.m = m; er.d = a + 32'(b); er.l = (b == int'(l));
            exp_r.push_back(er);
        end
    endtask

    task automatic request(input int m, input logic [31:0] a, input logic [7:0] l, input int cnt);
        pend_addr[m] = a;
        pend_len[m]  = l;
        pend_cnt[m]  = cnt;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_ar.size() != 0 || exp_r.size() != 0 || busy || s_arvalid != '0) && n < 600);
        if (n >= 600) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got ar=%0d r=%0d outstanding, required 0", name, exp_ar.size(), exp_r.size());
        end
        chk({name, "_grant_idle"}, 64'(grant), 64'h0);
    endtask

    task automatic reset_dut();
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // cache-controller side: hold a request until its AR handshake, then reload if more are queued
    initial begin
        logic [N-1:0] hs;
        s_arvalid = '0;
        s_araddr  = '0;
        s_arlen   = '0;
        for (int m = 0; m < N; m++) begin
            s_arsize[m]  = 3'd2;
            s_arburst[m] = 2'b01;
            pend_cnt[m]  = 0;
        end
        forever begin
            @(negedge clk);
            hs = s_arvalid & s_arready;
            @(posedge clk); #1;
            for (int m = 0; m < N; m++) begin
                if (hs[m]) s_arvalid[m] = 1'b0;
                if (!s_arvalid[m] && pend_cnt[m] > 0) begin
                    s_arvalid[m] = 1'b1;
                    s_araddr[m]  = pend_addr[m];
                    s_arlen[m]   = pend_len[m];
                    pend_cnt[m]--;
                    pend_addr[m] = pend_addr[m] + 32'h100;
                end
            end
        end
    end

    initial begin
        s_rready = '1;
        forever begin
            @(posedge clk); #1;
            s_rready = rr_toggle ? ~s_rready : '1;
        end
    end

    // memory model: returns data = address + beat index
    initial begin
        logic [31:0] a;
        logic [7:0]  l;
        bit          ok;
        int          guard;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rresp   = 2'b00;
        m_rlast   = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (m_arvalid && rst_n) begin
                a = m_araddr;
                l = m_arlen;
                repeat (ar_stall) begin @(posedge clk); #1; end
                m_arready = 1'b1;
                @(posedge clk); #1;
                m_arready = 1'b0;
                for (int b = 0; b <= int'(l); b++) begin
                    if (!rst_n) break;
                    if (r_gaps && (b % 2 == 1)) begin @(posedge clk); #1; end
                    m_rvalid = 1'b1;
                    m_rdata  = a + 32'(b);
                    m_rlast  = (b == int'(l));
                    ok = 1'b0;
                    guard = 0;
                    while (!ok && rst_n && guard < 100) begin
                        @(negedge clk);
                        ok = m_rready;
                        @(posedge clk); #1;
                        guard++;
                    end
                    if (guard >= 100) begin
                        checks++;
                        errors++;
                        $display("FAIL r_beat_stuck: got no rready for beat %0d, required handshake", b);
                    end
                    m_rvalid = 1'b0;
                    m_rlast  = 1'b0;
                end
            end
        end
    end

    // scoreboard monitor
    initial begin
        arexp_t ea;
        rexp_t  er;
        int     cyc = 0;
        int     last_rlast_cyc = 0;
        bit     have_rlast = 1'b0;
        bit     prev_arvalid = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (m_arvalid && !prev_arvalid && have_rlast)
                chk("ar_gap_ge2", 64'(cyc - last_rlast_cyc >= 2), 64'h1);
            prev_arvalid = m_arvalid;
            if (s_arready != '0)
                chk("arready_owner_only", 64'(s_arready & ~grant), 64'h0);
            if (m_arvalid && m_arready) begin
                if (exp_ar.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ar: got addr %0h, required none", m_araddr);
                end else begin
                    ea = exp_ar.pop_front();
                    chk("ar_grant", 64'(grant), 64'(1) << ea.m);
                    chk("ar_addr", 64'(m_araddr), 64'(ea.a));
                    chk("ar_len", 64'(m_arlen), 64'(ea.l));
                    chk("ar_size_burst", 64'({m_arsize, m_arburst}), 64'({3'd2, 2'b01}));
                end
            end
            if (s_rvalid != '0)
                chk("r_owner_only", 64'(s_rvalid & ~grant), 64'h0);
            for (int m = 0; m < N; m++) begin
                if (s_rvalid[m] && s_rready[m]) begin
                    r_hs_cnt++;
                    if (exp_r.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_r: got beat %0h at master %0d, required none", s_rdata[m], m);
                    end else begin
                        er = exp_r.pop_front();
                        chk("r_master", 64'(m), 64'(er.m));
                        chk("r_data", 64'(s_rdata[m]), 64'(er.d));
                        chk("r_last", 64'(s_rlast[m]), 64'(er.l));
                        if (s_rlast[m]) begin
                            last_rlast_cyc = cyc;
                            have_rlast = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500us, required completion");
        $fatal(1);
    end

    initial begin
        int base;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_arvalid", 64'(m_arvalid), 64'h0);
        chk("rst_rready", 64'(m_rready), 64'h0);
        chk("rst_s_arready", 64'(s_arready), 64'h0);
        chk("rst_s_rvalid", 64'(s_rvalid), 64'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // single request from master 2
        @(negedge clk);
        expect_burst(2, 32'h1000_0040, 8'd3);
        request(2, 32'h1000_0040, 8'd3, 1);
        @(negedge clk);
        chk("lat_req_cycle_arvalid", 64'(m_arvalid), 64'h0);
        @(negedge clk);
        chk("lat_next_cycle_arvalid", 64'(m_arvalid), 64'h1);
        chk("single_grant", 64'(grant), 64'h4);
        chk("single_busy", 64'(busy), 64'h1);
        wait_done("single");

        // all four at once after reset: 0,1,2,3
        reset_dut();
        @(negedge clk);
        for (int m = 0; m < N; m++) expect_burst(m, 32'h2000_0000 + 32'(m * 'h40), 8'd3);
        for (int m = 0; m < N; m++) request(m, 32'h2000_0000 + 32'(m * 'h40), 8'd3, 1);
        wait_done("all4");

        // fairness: 1 and 3 both keep requesting -> 1,3,1,3
        @(negedge clk);
        expect_burst(1, 32'h3000_0000, 8'd1);
        expect_burst(3, 32'h3300_0000, 8'd1);
        expect_burst(1, 32'h3000_0100, 8'd1);
        expect_burst(3, 32'h3300_0100, 8'd1);
        request(1, 32'h3000_0000, 8'd1, 2);
        request(3, 32'h3300_0000, 8'd1, 2);
        wait_done("fair");

        // backpressure on AR, gaps on R, toggling owner rready; master 2 waits its turn
        ar_stall  = 5;
        r_gaps    = 1'b1;
        rr_toggle = 1'b1;
        @(negedge clk);
        expect_burst(1, 32'h4000_0000, 8'd3);
        expect_burst(2, 32'h4200_0000, 8'd3);
        request(1, 32'h4000_0000, 8'd3, 1);
        request(2, 32'h4200_0000, 8'd3, 1);
        repeat (4) @(negedge clk);
        chk("bp_stall_grant", 64'(grant), 64'h2);
        chk("bp_pending_arready", 64'(s_arready), 64'h0);
        chk("wr_m_awvalid", 64'(m_awvalid), 64'h0);
        chk("wr_m_wvalid", 64'(m_wvalid), 64'h0);
        chk("wr_m_bready", 64'(m_bready), 64'h0);
        chk("wr_s_awready", 64'(s_awready), 64'h0);
        chk("wr_s_wready", 64'(s_wready), 64'h0);
        chk("wr_s_bvalid", 64'(s_bvalid), 64'h0);
        wait_done("bp");
        ar_stall  = 0;
        r_gaps    = 1'b0;
        rr_toggle = 1'b0;

        // reset after beat 2 of 4 (last owner was 2, so master 0 wins)
        @(negedge clk);
        expect_burst(0, 32'h5000_0000, 8'd3);
        request(0, 32'h5000_0000, 8'd3, 1);
        base = r_hs_cnt;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (r_hs_cnt >= base + 2) break;
        end
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_grant", 64'(grant), 64'h0);
        chk("midrst_busy", 64'(busy), 64'h0);
        chk("midrst_rready", 64'(m_rready), 64'h0);
        chk("midrst_s_rvalid", 64'(s_rvalid), 64'h0);
        chk("midrst_arvalid", 64'(m_arvalid), 64'h0);
        chk("midrst_beats_left", 64'(exp_r.size()), 64'd2);
        exp_r.delete();
        exp_ar.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;

        // after reset master 0 again has first priority over master 3
        @(negedge clk);
        expect_burst(0, 32'h6000_0000, 8'd1);
        expect_burst(3, 32'h6300_0000, 8'd1);
        request(3, 32'h6300_0000, 8'd1, 1);
        request(0, 32'h6000_0000, 8'd1, 1);
        wait_done("post_rst_both");

        @(negedge clk);
        expect_burst(3, 32'h7300_0000, 8'd0);
        request(3, 32'h7300_0000, 8'd0, 1);
        wait_done("post_rst_m3");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
